// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer:
// op codes, status bit positions and sequencer states.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_SUB = 2'b00,
      OP_CMP = 2'b01,
      OP_SHL = 2'b10,
      OP_CHG = 2'b11
   } alu_op_t;

   localparam int ERROR_BIT  = 0;
   localparam int EVEN_BIT   = 1;
   localparam int OVF_BIT    = 2;
   localparam int SINGLE_BIT = 3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr)
         cnt_d = '0;
      else if (i_inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives one command at a time into a fixed-latency ALU, waits out the
// pipeline, and hands the captured result/status back over valid/ready.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int BITS  = 8,
   parameter int LAT   = 2,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [BITS-1:0]  i_cmd_a,
   input  logic [BITS-1:0]  i_cmd_b,
   input  logic [1:0]       i_cmd_op,
   output logic [BITS-1:0]  o_alu_a,
   output logic [BITS-1:0]  o_alu_b,
   output logic [1:0]       o_alu_op,
   input  logic [BITS-1:0]  i_alu_out,
   input  logic [3:0]       i_alu_status,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [BITS-1:0]  o_rsp_data,
   output logic [3:0]       o_rsp_status,
   output logic [1:0]       o_rsp_op,
   input  logic             i_err_clr,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_busy
);

   seq_state_t      state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [BITS-1:0] alu_a_q, alu_a_d;
   logic [BITS-1:0] alu_b_q, alu_b_d;
   alu_op_t         alu_op_q, alu_op_d;
   alu_op_t         rsp_op_q, rsp_op_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [BITS-1:0] rsp_data_q, rsp_data_d;
   logic [3:0]      rsp_status_q, rsp_status_d;
   logic            capture;

   // ALU result is only trusted on the single edge where the wait count has run out.
   assign capture = (state_q == WAIT) && (cnt_q == 4'd0);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_op_d     = rsp_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      case (state_q)
         IDLE: begin
            if (i_cmd_valid) begin
               alu_a_d  = i_cmd_a;
               alu_b_d  = i_cmd_b;
               alu_op_d = alu_op_t'(i_cmd_op);
               rsp_op_d = alu_op_t'(i_cmd_op);
               cnt_d    = 4'(LAT);
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (capture) begin
               rsp_data_d   = i_alu_out;
               rsp_status_d = i_alu_status;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= OP_SUB;
         rsp_op_q     <= OP_SUB;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_op_q     <= rsp_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (capture & i_alu_status[ERROR_BIT]),
      .i_clr (i_err_clr),
      .o_cnt (o_err_cnt)
   );

   // State sits at IDLE during reset, so ready must also be masked by reset.
   assign o_cmd_ready  = (state_q == IDLE) && !i_rst;
   assign o_busy       = (state_q != IDLE);
   assign o_alu_a      = alu_a_q;
   assign o_alu_b      = alu_b_q;
   assign o_alu_op     = alu_op_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_data   = rsp_data_q;
   assign o_rsp_status = rsp_status_q;
   assign o_rsp_op     = rsp_op_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a stub ALU pipeline plus a response/timing
// and error-count reference model.
module tb_alu_cmd_sequencer;

   localparam int BITS  = 8;
   localparam int LAT   = 2;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_cmd_valid = 1'b0;
   logic             o_cmd_ready;
   logic [BITS-1:0]  i_cmd_a = '0, i_cmd_b = '0;
   logic [1:0]       i_cmd_op = '0;
   logic [BITS-1:0]  o_alu_a, o_alu_b;
   logic [1:0]       o_alu_op;
   logic [BITS-1:0]  i_alu_out;
   logic [3:0]       i_alu_status;
   logic             o_rsp_valid;
   logic             i_rsp_ready = 1'b0;
   logic [BITS-1:0]  o_rsp_data;
   logic [3:0]       o_rsp_status;
   logic [1:0]       o_rsp_op;
   logic             i_err_clr = 1'b0;
   logic [CNT_W-1:0] o_err_cnt;
   logic             o_busy;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int ecnt = 0;
   logic err_force = 1'b0;
   logic noise = 1'b0;

   alu_cmd_sequencer #(.BITS(BITS), .LAT(LAT), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_op(i_cmd_op),
      .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
      .i_alu_out(i_alu_out), .i_alu_status(i_alu_status),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_status(o_rsp_status), .o_rsp_op(o_rsp_op),
      .i_err_clr(i_err_clr), .o_err_cnt(o_err_cnt), .o_busy(o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stub ALU: {status, out}; ERROR is forced by the bench.
   function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op, input logic e);
      logic [7:0] r;
      logic [3:0] s;
      case (op)
         2'b00:   r = a - b;
         2'b01:   r = (a < b) ? 8'd1 : 8'd0;
         2'b10:   r = a << b[2:0];
         default: r = a ^ b;
      endcase
      s[0] = e;
      s[1] = ~r[0];
      s[2] = (op == 2'b00) && (b > a);
      s[3] = $onehot(r);
      return {s, r};
   endfunction

   logic [11:0] pipe [LAT];
   logic [7:0]  junk;
   always @(posedge clk) begin
      pipe[0] <= alu_fn(o_alu_a, o_alu_b, o_alu_op, err_force);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   always @(negedge clk) junk <= 8'($urandom);
   assign i_alu_out    = noise ? junk      : pipe[LAT-1][7:0];
   assign i_alu_status = noise ? junk[3:0] : pipe[LAT-1][11:8];

   task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input int bp, input bit clr_cap);
      logic [11:0] exp;
      int n;
      exp = alu_fn(a, b, op, err_force);
      @(negedge clk);
      i_cmd_valid = 1'b1; i_cmd_a = a; i_cmd_b = b; i_cmd_op = op;
      nvec++; if (o_cmd_ready !== 1'b1) begin nerr++; $display("FAIL cmd_ready_idle got %b exp 1", o_cmd_ready); end
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
      nvec++; if ({o_alu_a, o_alu_b, o_alu_op} !== {a, b, op}) begin
         nerr++; $display("FAIL alu_regs got %h/%h/%h exp %h/%h/%h", o_alu_a, o_alu_b, o_alu_op, a, b, op); end
      nvec++; if ({o_busy, o_cmd_ready, o_rsp_valid} !== 3'b100) begin
         nerr++; $display("FAIL after_accept busy/rdy/vld got %b exp 100", {o_busy, o_cmd_ready, o_rsp_valid}); end
      n = 0;
      while (!o_rsp_valid && n < 20) begin
         @(negedge clk);
         if (clr_cap && n == LAT) i_err_clr = 1'b1;
         @(posedge clk); #1;
         i_err_clr = 1'b0;
         n++;
         nvec++; if ({o_alu_a, o_alu_b, o_alu_op} !== {a, b, op}) begin
            nerr++; $display("FAIL alu_hold got %h/%h/%h exp %h/%h/%h", o_alu_a, o_alu_b, o_alu_op, a, b, op); end
      end
      nvec++; if (n != LAT + 1) begin nerr++; $display("FAIL rsp_latency got %0d exp %0d", n, LAT + 1); end
      if (clr_cap)      ecnt = 0;
      else if (exp[8])  ecnt = (ecnt == 3) ? 3 : ecnt + 1;
      nvec++; if ({o_rsp_status, o_rsp_data} !== exp) begin
         nerr++; $display("FAIL rsp_data got %h/%h exp %h/%h", o_rsp_status, o_rsp_data, exp[11:8], exp[7:0]); end
      nvec++; if (o_rsp_op !== op) begin nerr++; $display("FAIL rsp_op got %b exp %b", o_rsp_op, op); end
      nvec++; if (o_err_cnt !== CNT_W'(ecnt)) begin nerr++; $display("FAIL err_cnt got %0d exp %0d", o_err_cnt, ecnt); end
      noise = 1'b1;
      repeat (bp) begin
         @(negedge clk); i_rsp_ready = 1'b0;
         @(posedge clk); #1;
         nvec++; if ({o_rsp_valid, o_cmd_ready, o_busy, o_rsp_data} !== {3'b101, exp[7:0]}) begin
            nerr++; $display("FAIL backpressure vld/rdy/busy/data got %b%b%b/%h exp 101/%h",
                             o_rsp_valid, o_cmd_ready, o_busy, o_rsp_data, exp[7:0]); end
      end
      @(negedge clk); i_rsp_ready = 1'b1;
      @(posedge clk); #1;
      noise = 1'b0;
      nvec++; if ({o_rsp_valid, o_cmd_ready, o_busy} !== 3'b010) begin
         nerr++; $display("FAIL handshake vld/rdy/busy got %b exp 010", {o_rsp_valid, o_cmd_ready, o_busy}); end
      nvec++; if ({o_alu_a, o_alu_b} !== {a, b}) begin
         nerr++; $display("FAIL alu_keep_idle got %h/%h exp %h/%h", o_alu_a, o_alu_b, a, b); end
      @(negedge clk); i_rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #23;
      nvec++; if (o_cmd_ready !== 1'b0) begin nerr++; $display("FAIL ready_in_reset got %b exp 0", o_cmd_ready); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      nvec++; if ({o_cmd_ready, o_busy} !== 2'b10) begin nerr++; $display("FAIL post_reset rdy/busy got %b exp 10", {o_cmd_ready, o_busy}); end
      err_force = 1'b1;
      run_cmd(8'h5A, 8'hC3, 2'b11, 0, 1'b0);
      err_force = 1'b0;
      @(negedge clk); i_cmd_valid = 1'b1; i_cmd_a = 8'h77; i_cmd_b = 8'h11; i_cmd_op = 2'b10;
      @(posedge clk); #1; i_cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      nvec++; if ({o_cmd_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_data, o_rsp_status,
                   o_rsp_op, o_err_cnt, o_busy} !== '0) begin
         nerr++; $display("FAIL async_reset_outputs got %h exp 0", {o_cmd_ready, o_alu_a, o_alu_b, o_alu_op,
                          o_rsp_valid, o_rsp_data, o_rsp_status, o_rsp_op, o_err_cnt, o_busy}); end
      ecnt = 0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      nvec++; if ({o_cmd_ready, o_busy} !== 2'b10) begin nerr++; $display("FAIL release rdy/busy got %b exp 10", {o_cmd_ready, o_busy}); end
   endtask

   task automatic test_single_sub();
      run_cmd(8'h0A, 8'h03, 2'b00, 0, 1'b0);
      nvec++; if (o_rsp_data !== 8'h07) begin nerr++; $display("FAIL sub_result got %h exp 07", o_rsp_data); end
   endtask

   task automatic test_backpressure();
      run_cmd(8'h0A, 8'h03, 2'b00, 5, 1'b0);
   endtask

   task automatic test_err_count();
      logic [CNT_W-1:0] tab [4];
      tab[0] = 2'd1; tab[1] = 2'd2; tab[2] = 2'd3; tab[3] = 2'd3;
      err_force = 1'b1;
      for (int k = 0; k < 4; k++) begin
         run_cmd(8'($urandom), 8'($urandom), 2'($urandom), 0, 1'b0);
         nvec++; if (o_err_cnt !== tab[k]) begin nerr++; $display("FAIL err_seq%0d got %0d exp %0d", k, o_err_cnt, tab[k]); end
      end
      @(negedge clk); i_err_clr = 1'b1;
      @(posedge clk); #1; i_err_clr = 1'b0; ecnt = 0;
      nvec++; if (o_err_cnt !== '0) begin nerr++; $display("FAIL err_clr got %0d exp 0", o_err_cnt); end
      run_cmd(8'h10, 8'h20, 2'b01, 0, 1'b0);
      run_cmd(8'h30, 8'h01, 2'b10, 0, 1'b1);
      nvec++; if (o_err_cnt !== '0) begin nerr++; $display("FAIL clr_beats_inc got %0d exp 0", o_err_cnt); end
      err_force = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         err_force = 1'($urandom);
         run_cmd(8'($urandom), 8'($urandom), 2'($urandom), $urandom_range(0, 3), 1'b0);
      end
      err_force = 1'b0;
   endtask

   task automatic test_mid_wait_reset();
      bit seen;
      @(negedge clk); i_cmd_valid = 1'b1; i_cmd_a = 8'hA5; i_cmd_b = 8'h0F; i_cmd_op = 2'b01;
      @(posedge clk); #1; i_cmd_valid = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      #1;
      nvec++; if ({o_alu_a, o_alu_b, o_alu_op, o_busy, o_rsp_valid} !== '0) begin
         nerr++; $display("FAIL mid_wait_reset got %h exp 0", {o_alu_a, o_alu_b, o_alu_op, o_busy, o_rsp_valid}); end
      ecnt = 0;
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      i_rsp_ready = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (o_rsp_valid || o_busy) seen = 1'b1;
      end
      i_rsp_ready = 1'b0;
      nvec++; if (seen) begin nerr++; $display("FAIL ghost_response got 1 exp 0"); end
      run_cmd(8'h44, 8'h04, 2'b00, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [1:0]  ops [3];
      logic [13:0] q [$];
      logic [13:0] f;
      int acc [3];
      int k, got, t;
      bit acc_now;
      ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b11;
      k = 0; got = 0; t = 0;
      @(negedge clk);
      i_rsp_ready = 1'b1; i_cmd_valid = 1'b1;
      i_cmd_a = 8'($urandom); i_cmd_b = 8'($urandom); i_cmd_op = ops[0];
      while (got < 3 && t < 60) begin
         acc_now = 1'b0;
         if (t > 0) @(negedge clk);
         if (o_rsp_valid) begin
            nvec++;
            if (q.size() == 0) begin nerr++; $display("FAIL b2b_unexpected_rsp got op %b exp none", o_rsp_op); end
            else begin
               f = q.pop_front();
               if ({o_rsp_op, o_rsp_status, o_rsp_data} !== f) begin
                  nerr++; $display("FAIL b2b_rsp got %b/%h/%h exp %b/%h/%h", o_rsp_op, o_rsp_status, o_rsp_data,
                                   f[13:12], f[11:8], f[7:0]); end
            end
            got++;
         end
         if (o_cmd_ready && i_cmd_valid) begin
            q.push_back({i_cmd_op, alu_fn(i_cmd_a, i_cmd_b, i_cmd_op, 1'b0)});
            acc[k] = cyc; k++; acc_now = 1'b1;
         end
         @(posedge clk); #1;
         if (acc_now) begin
            if (k < 3) begin i_cmd_a = 8'($urandom); i_cmd_b = 8'($urandom); i_cmd_op = ops[k]; end
            else i_cmd_valid = 1'b0;
         end
         t++;
      end
      i_cmd_valid = 1'b0;
      nvec++; if (got != 3 || k != 3) begin nerr++; $display("FAIL b2b_count got %0d/%0d exp 3/3", k, got); end
      if (k == 3) begin
         nvec++; if (acc[1] - acc[0] != LAT + 3) begin nerr++; $display("FAIL b2b_interval1 got %0d exp %0d", acc[1] - acc[0], LAT + 3); end
         nvec++; if (acc[2] - acc[1] != LAT + 3) begin nerr++; $display("FAIL b2b_interval2 got %0d exp %0d", acc[2] - acc[1], LAT + 3); end
      end
      @(negedge clk); i_rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_sub();
      test_backpressure();
      test_err_count();
      test_random();
      test_back_to_back();
      test_mid_wait_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator-side companion to the team's 4-op ALU (SUB / CMP / SHL / CHG, 4-bit status).
- Accepts operand/op commands over a valid/ready interface and drives the ALU operand/op inputs, holding them stable.
- Waits the ALU's fixed pipeline latency, captures result and status, and returns them over a valid/ready response interface.
- One command is in flight at a time. The block also keeps a saturating count of ALU error results.

Parameters:
- BITS, 8, operand/result width; must match the ALU instance.
- LAT, 2, ALU latency in clock edges from operands applied to result valid; range 1..15.
- CNT_W, 8, width of the error counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command ready; high only in IDLE.
- i_cmd_a  in  BITS  operand A.
- i_cmd_b  in  BITS  operand B.
- i_cmd_op  in  2  op code: 00 SUB, 01 CMP, 10 SHL, 11 CHG.
- o_alu_a  out  BITS  to ALU i_a, registered.
- o_alu_b  out  BITS  to ALU i_b, registered.
- o_alu_op  out  2  to ALU i_op, registered.
- i_alu_out  in  BITS  from ALU o_out.
- i_alu_status  in  4  from ALU o_status: bit0 ERROR, bit1 EVEN, bit2 OVF, bit3 SINGLE.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response ready.
- o_rsp_data  out  BITS  captured result.
- o_rsp_status  out  4  captured status.
- o_rsp_op  out  2  op code of the response.
- i_err_clr  in  1  synchronous clear of the error counter.
- o_err_cnt  out  CNT_W  saturating error count.
- o_busy  out  1  high in WAIT or RESP.

Behaviour:
- Reset: one clock, i_clk; reset i_rst is asynchronous, active-high. While asserted, all outputs and registers are 0, state is IDLE, and o_cmd_ready is 0 during reset. Reset mid-operation discards the in-flight command; no response is ever produced for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid&o_cmd_ready at edge E0: register a/b/op into o_alu_* and o_rsp_op, load wait counter with LAT, go to WAIT.
- WAIT:
  - o_alu_* held constant.
  - Counter decrements each edge while nonzero.
  - At the edge where counter==0, i.e. edge E(LAT+1): capture i_alu_out → o_rsp_data and i_alu_status → o_rsp_status, set o_rsp_valid=1, go to RESP.
  - ALU inputs are ignored on every other edge.
- RESP:
  - o_rsp_valid=1; o_rsp_data, o_rsp_status and o_rsp_op are stable until handshake.
  - On o_rsp_valid&i_rsp_ready: o_rsp_valid=0, go to IDLE.
  - o_cmd_ready stays 0 in this state, so a command presented during the response handshake is accepted at the next edge at the earliest.
- Throughput: at most one command per LAT+3 cycles when i_rsp_ready is held high.
- o_alu_* keep their last values in IDLE; they are not cleared after a response.
- Error counter:
  - Increments at the capture edge when i_alu_status[0]=1.
  - Saturates at all ones.
  - i_err_clr=1 sets it to 0; clear wins over a simultaneous increment.
- CMP results are passed through unchanged; zero-extension is the ALU's job.

Decomposition:
- Package alu_pkg holds:
  - op enum: OP_SUB=2'b00, OP_CMP=2'b01, OP_SHL=2'b10, OP_CHG=2'b11.
  - status bit index constants: ERROR_BIT=0, EVEN_BIT=1, OVF_BIT=2, SINGLE_BIT=3.
  - seq_state_t enum {IDLE, WAIT, RESP}.
- One sub-module: sat_counter, parameterised by width, with inc/clr inputs and clr priority. It is used for o_err_cnt.
- The FSM and datapath registers stay in the top level.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle → all outputs 0 immediately; after release o_cmd_ready=1 at the next cycle, o_busy=0.
- Single SUB, bench ALU model with LAT=2:
  - Stimulus: a=0x0A, b=0x03, op=00; model returns 0x07 and status 4'b0000.
  - o_alu_a=0x0A, o_alu_b=0x03, o_alu_op=00 from E0, held through WAIT.
  - o_rsp_valid rises at E3 with o_rsp_data=0x07, o_rsp_op=00.
- Backpressure: i_rsp_ready=0 for 5 cycles while the model toggles i_alu_out → o_rsp_data stays 0x07, o_cmd_ready=0, o_busy=1. Response completes on the first ready cycle.
- Error counting with CNT_W=2:
  - Four commands with status bit0=1 → o_err_cnt 1, 2, 3, 3.
  - i_err_clr → 0.
  - i_err_clr coinciding with an error capture → 0.
- Reset mid-WAIT: assert i_rst one cycle after E0 → o_alu_*=0, FSM in IDLE, no o_rsp_valid pulse ever; a new command after release completes normally.
- Back-to-back: i_cmd_valid held high with i_rsp_ready=1 → second command accepted one cycle after the response handshake; commands accepted every LAT+3=5 cycles; op codes 01/10/11 reported correctly in o_rsp_op.
